// File: rtl/cmd_parser.sv
// cmd_parser: sequential host-command parser sitting between the UART receiver
// and the master control FSM.
//
// One-byte commands (connect / start / software reset) each produce a
// registered single-cycle pulse one clock after the strobe. The set-samples
// command is followed by ARG_BYTES payload bytes, shifted in MSB-first and
// loaded into the samples register when the last one arrives. Argument
// collection is abandoned if the line stays idle for too long between bytes.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   byte_in      received byte, qualified by byte_valid
//   byte_valid   one-cycle strobe from the UART receiver
//   connect      pulse: connection request
//   start        pulse: start correlation
//   sw_reset     pulse: software reset
//   samples_load pulse: samples updated this cycle
//   samples      sample count, held between loads
//   busy         high while collecting argument bytes
//   err_unknown  pulse: unrecognised command byte
//   err_timeout  pulse: argument collection aborted on timeout

module cmd_parser #(
    parameter logic [7:0]   CONNECT_BYTE     = 8'd99,
    parameter logic [7:0]   START_BYTE       = 8'd115,
    parameter logic [7:0]   RESET_BYTE       = 8'd114,
    parameter logic [7:0]   SET_SAMPLES_BYTE = 8'd116,
    parameter int unsigned  ARG_BYTES        = 4,
    parameter int unsigned  TIMEOUT_CYCLES   = 1000000,
    parameter logic [8*ARG_BYTES-1:0] SAMPLES_DEFAULT = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic                   connect,
    output logic                   start,
    output logic                   sw_reset,
    output logic                   samples_load,
    output logic [8*ARG_BYTES-1:0] samples,
    output logic                   busy,
    output logic                   err_unknown,
    output logic                   err_timeout
);

    localparam int unsigned DATA_W = 8 * ARG_BYTES;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned IDX_W  = $clog2(ARG_BYTES + 1);

    // The pulse is registered, so the expiry decision is taken one cycle
    // before the counter itself would read TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ARG_BYTES - 1);

    typedef enum logic [0:0] {
        StIdle,
        StArg
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   samples_q, samples_d;
    logic [DATA_W-1:0]   shift_next;

    logic connect_q, connect_d;
    logic start_q, start_d;
    logic sw_reset_q, sw_reset_d;
    logic load_q, load_d;
    logic err_unknown_q, err_unknown_d;
    logic err_timeout_q, err_timeout_d;

    // MSB-first shift; a single-byte argument is just the byte itself.
    generate
        if (ARG_BYTES == 1) begin : g_shift_one
            assign shift_next = byte_in;
        end else begin : g_shift_many
            assign shift_next = {shift_q[DATA_W-9:0], byte_in};
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        samples_d     = samples_q;
        connect_d     = 1'b0;
        start_d       = 1'b0;
        sw_reset_d    = 1'b0;
        load_d        = 1'b0;
        err_unknown_d = 1'b0;
        err_timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (byte_valid) begin
                    if (byte_in == CONNECT_BYTE) begin
                        connect_d = 1'b1;
                    end else if (byte_in == START_BYTE) begin
                        start_d = 1'b1;
                    end else if (byte_in == RESET_BYTE) begin
                        sw_reset_d = 1'b1;
                    end else if (byte_in == SET_SAMPLES_BYTE) begin
                        state_d = StArg;
                        idx_d   = '0;
                        cnt_d   = '0;
                        shift_d = '0;
                    end else begin
                        err_unknown_d = 1'b1;
                    end
                end
            end

            StArg: begin
                // Every byte here is payload, command values included.
                // A byte in the expiry cycle wins over the timeout.
                if (byte_valid) begin
                    shift_d = shift_next;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        samples_d = shift_next;
                        load_d    = 1'b1;
                        idx_d     = '0;
                        state_d   = StIdle;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = StIdle;
                    cnt_d         = '0;
                    idx_d         = '0;
                    shift_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            cnt_q         <= '0;
            shift_q       <= '0;
            samples_q     <= SAMPLES_DEFAULT;
            connect_q     <= 1'b0;
            start_q       <= 1'b0;
            sw_reset_q    <= 1'b0;
            load_q        <= 1'b0;
            err_unknown_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            samples_q     <= samples_d;
            connect_q     <= connect_d;
            start_q       <= start_d;
            sw_reset_q    <= sw_reset_d;
            load_q        <= load_d;
            err_unknown_q <= err_unknown_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign connect      = connect_q;
    assign start        = start_q;
    assign sw_reset     = sw_reset_q;
    assign samples_load = load_q;
    assign samples      = samples_q;
    assign busy         = (state_q == StArg);
    assign err_unknown  = err_unknown_q;
    assign err_timeout  = err_timeout_q;

endmodule

// File: doc/cmd_parser.md
# cmd_parser

Sequential host-command parser between the UART receiver and the master control FSM. It replaces the purely combinational byte decoder. Each one-byte command produces a registered single-cycle pulse. The set-samples command collects a parametrised number of argument bytes into a sample-count register, with an inter-byte timeout and error reporting.

## Interface
Parameters:
- CONNECT_BYTE, 8'd99: 'c', connection request.
- START_BYTE, 8'd115: 's', start correlation.
- RESET_BYTE, 8'd114: 'r', software reset.
- SET_SAMPLES_BYTE, 8'd116: 't', followed by ARG_BYTES argument bytes.
- ARG_BYTES, 4: argument length in bytes, legal range 1..8.
- TIMEOUT_CYCLES, 1000000: maximum idle clocks between argument bytes, ≥2.
- SAMPLES_DEFAULT, 0: reset value of samples.

Ports (one clock; reset is asynchronous and active-high):
- clk, in, 1: system clock; all logic on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- byte_in, in, 8: received byte, qualified by byte_valid.
- byte_valid, in, 1: one-cycle strobe from the UART receiver.
- connect, out, 1: single-cycle pulse.
- start, out, 1: single-cycle pulse.
- sw_reset, out, 1: single-cycle pulse.
- samples_load, out, 1: single-cycle pulse; samples updated this cycle.
- samples, out, 8*ARG_BYTES: sample count, held between loads.
- busy, out, 1: high while collecting argument bytes.
- err_unknown, out, 1: single-cycle pulse; unrecognised command byte.
- err_timeout, out, 1: single-cycle pulse; argument collection aborted.

## Operation
- Two states: IDLE and ARG.
- IDLE, byte_valid with a command byte:
  - connect, start or reset byte: pulse the matching output.
  - SET_SAMPLES_BYTE: go to ARG, clear the byte index, clear the timeout counter, clear the shift register.
  - Any other value: pulse err_unknown.
- ARG:
  - Each valid byte is shifted in MSB-first: shift = {shift[8*ARG_BYTES-9:0], byte_in}, and the index increments.
  - In ARG, every byte value is payload, including 'c', 's', 'r' and 't'. None of them is decoded as a command.
  - On the ARG_BYTES-th byte: samples loads the complete value, samples_load pulses, state returns to IDLE.
  - The timeout counter clears on every valid byte and increments otherwise. If it reaches TIMEOUT_CYCLES-1 with no byte, err_timeout pulses, state returns to IDLE, samples stays unchanged and partial data is discarded.
  - If byte_valid arrives in the same cycle the counter would expire, the byte is accepted and no timeout occurs.
- busy = (state == ARG).
- No more than one output pulse is ever active per cycle.
- Counter width is $clog2(TIMEOUT_CYCLES). Index width is $clog2(ARG_BYTES+1).

## Timing
- Reset: every pulse output is 0, busy is 0, state is IDLE, samples = SAMPLES_DEFAULT, shift register, index and timeout counter are 0.
- Reset asserted mid-ARG aborts collection immediately. No pulse is generated and samples returns to SAMPLES_DEFAULT.
- Command latency: byte_valid at cycle N gives the pulse at N+1, lasting exactly 1 cycle.
- Argument latency: last argument byte at cycle N gives samples valid and samples_load at N+1. busy is high from N+1 after the 't' byte through cycle N, and low at N+1.
- Back-to-back byte_valid on consecutive cycles is accepted in both states. A command byte in the cycle right after the final argument byte is decoded normally.
- Timeout: the last valid byte (or 't') at cycle N with no further byte gives err_timeout at N+TIMEOUT_CYCLES and busy low in that same cycle.
- Outputs are registered; no combinational path exists from byte_in to any output.

## Test plan
- Reset, then bytes 0x63, 0x73, 0x72 with 3-cycle gaps: connect, then start, then sw_reset, each 1 cycle wide, each 1 cycle after its strobe. samples = 0 throughout.
- With ARG_BYTES=4, send 0x74, 0x00, 0x01, 0x86, 0xA0 back-to-back: samples = 0x000186A0 and samples_load for 1 cycle after the last byte. busy is high for exactly 4 cycles.
- With TIMEOUT_CYCLES=16, send 0x74, 0x12, then silence: err_timeout exactly 16 cycles after 0x12. samples stays at its previous value and busy drops. A following 0x73 pulses start.
- Send 0x74, 0x73, 0x63, 0x72, 0x74: samples = 0x7363 7274 and no command pulses. Then send 0x41: err_unknown pulse and samples unchanged.
- With TIMEOUT_CYCLES=16, send a byte exactly in the expiry cycle: it is accepted and there is no err_timeout. Separately, assert rst after 2 of 4 argument bytes: all outputs at reset values. A following full sequence loads correctly.
- With ARG_BYTES=1, send 0x74, 0xFF: samples = 8'hFF and samples_load asserted.
